// File: rtl/rr_grant_ctl.sv
// rtl/rr_grant_ctl.sv - round-robin grant controller with a dead cycle between owners.
// Optional hold-time watchdog enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_ctl #(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic          gnt_stb,
    output logic [IW-1:0] owner,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    generate
        if (N < 2 || N > 8 || IW != $clog2(N) || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
            $error("rr_grant_ctl: illegal parameter combination");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_stb_q, gnt_stb_d;
    logic          busy_q, busy_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] ptr_next;
    logic          rel_req;
    logic          hold_expire;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_expire = (state_q == ST_GRANT) && (hold_q == HOLD_LIMIT);
    assign timeout     = timeout_q;
`else
    assign hold_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Rotating-priority search starting at ptr; first requester found wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!win_found && req[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    assign rel_req  = done[owner_q] | ~req[owner_q];
    assign ptr_next = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            gnt_stb_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            gnt_stb_q <= gnt_stb_d;
            busy_q    <= busy_d;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_req || hold_expire) begin
                    state_d = ST_RELEASE;
                    ptr_d   = ptr_next;
                end
            end
            ST_RELEASE: begin
                state_d = win_found ? ST_GRANT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead from the next state and registered.
    always_comb begin
        owner_d   = owner_q;
        gnt_d     = '0;
        gnt_stb_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
`ifdef RR_GRANT_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        if (state_d == ST_GRANT && state_q != ST_GRANT) begin
            owner_d   = win_idx;
            gnt_d     = ONE << win_idx;
            gnt_stb_d = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_d    = '0;
`endif
        end else if (state_d == ST_GRANT) begin
            gnt_d = gnt_q;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_d = hold_q + 8'd1;
`endif
        end
`ifdef RR_GRANT_TIMEOUT_EN
        // A genuine release in the limit cycle wins over the watchdog.
        if (state_q == ST_GRANT && state_d == ST_RELEASE && !rel_req) begin
            timeout_d = 1'b1;
        end
`endif
    end

    assign gnt     = gnt_q;
    assign gnt_stb = gnt_stb_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_grant_ctl.sv
// tb/tb_rr_grant_ctl.sv - scoreboard bench for rr_grant_ctl against a behavioural model.
module tb_rr_grant_ctl;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int MAX_HOLD = 16;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]  gnt;
        logic          stb;
        logic [IW-1:0] owner;
        logic          busy;
        logic          to;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_stb;
    logic [IW-1:0] owner;
    logic          busy;
    logic          timeout;

    rr_grant_ctl #(.N(N), .IW(IW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_stb (gnt_stb),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_total = 0;
    int   n_pass  = 0;
    bit   armed   = 1'b0;
    exp_t exp_q[$];

    // Reference model: who owns the resource, how long it has held it,
    // and where the rotating search starts.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        exp_t e;
        bit   rel;
        bit   expire;
        int   w;
        e.gnt = '0; e.stb = 1'b0; e.busy = 1'b0; e.to = 1'b0;
        if (r) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            rel    = dn[m_owner] || !rq[m_owner];
            expire = TO_EN && !rel && (m_held == MAX_HOLD);
            e.busy = 1'b1;
            if (rel || expire) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                e.to    = expire;
            end else begin
                e.gnt = N'(1) << m_owner;
            end
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 0;
                e.gnt   = N'(1) << w;
                e.stb   = 1'b1;
                e.busy  = 1'b1;
            end
        end
        e.owner = IW'(m_last);
        return e;
    endfunction

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        exp_q.push_back(model_step(r, rq, dn));
        armed = 1'b1;
        if (r) begin
            #1;
            check("async_rst_gnt", 32'(gnt), 32'h0);
            check("async_rst_busy", 32'(busy), 32'h0);
            check("async_rst_stb", 32'(gnt_stb), 32'h0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_empty: got no expectation required one at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt", 32'(gnt), 32'(e.gnt));
                    check("gnt_stb", 32'(gnt_stb), 32'(e.stb));
                    check("owner", 32'(owner), 32'(e.owner));
                    check("busy", 32'(busy), 32'(e.busy));
                    check("timeout", 32'(timeout), 32'(e.to));
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        rst = 1'b1; req = '0; done = '0;
        drive(1'b1, '0, '0);
        drive(1'b0, '0, '0);

        // single request, then done
        repeat (3) drive(1'b0, 4'b0100, '0);
        drive(1'b0, 4'b0100, 4'b0100);
        repeat (3) drive(1'b0, '0, '0);

        // continuous full request, owner releases in its third grant cycle
        repeat (22) begin
            dn = (m_owner >= 0 && m_held == 2) ? 4'b1111 : 4'b0000;
            drive(1'b0, 4'b1111, dn);
        end
        repeat (2) drive(1'b0, '0, '0);

        // rotating priority after owner 1 releases
        repeat (3) drive(1'b0, 4'b0010, '0);
        drive(1'b0, 4'b0010, 4'b0010);
        repeat (3) drive(1'b0, 4'b1010, '0);
        drive(1'b0, 4'b1010, 4'b1000);
        repeat (3) drive(1'b0, 4'b1010, '0);
        drive(1'b0, '0, '0);
        repeat (2) drive(1'b0, '0, '0);

        // long hold: watchdog fires when enabled, grant persists otherwise
        repeat (110) drive(1'b0, 4'b0001, '0);
        repeat (2) drive(1'b0, '0, '0);

        // non-owner done ignored, owner drops req
        repeat (5) drive(1'b0, 4'b0001, 4'b0010);
        repeat (3) drive(1'b0, '0, '0);

        // reset mid-grant with owner 3
        repeat (4) drive(1'b0, 4'b1000, '0);
        drive(1'b1, 4'b1000, '0);
        repeat (3) drive(1'b0, 4'b1001, '0);
        drive(1'b0, 4'b1001, 4'b1111);
        repeat (2) drive(1'b0, '0, '0);

        // randomized traffic
        rq = '0;
        repeat (3000) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7, 0) == 0) rq[b] = ~rq[b];
            end
            dn = ($urandom_range(5, 0) == 0) ? N'($urandom) : '0;
            drive(($urandom_range(499, 0) == 0), rq, dn);
        end
        drive(1'b0, '0, '0);

        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
